// File: rtl/idea_pkg.sv
// ---------------------------------------------------------------------------
// idea_pkg
//   Shared IDEA constants and types. Used by the key expander and by the
//   decryption-key inverter downstream.
//
//   Contents:
//     IDEA_SUBKEY_W     width of one subkey (16)
//     IDEA_NUM_SUBKEYS  number of encryption subkeys (52)
//     IDEA_LIST_W       packed subkey list width, 56 slots x 16 (896)
//     IDEA_ROT          key-schedule rotation distance (25)
//     idea_state_e      expander FSM states {IDLE, RUN, DONE}
// ---------------------------------------------------------------------------
package idea_pkg;

  localparam int IDEA_SUBKEY_W    = 16;
  localparam int IDEA_NUM_SUBKEYS = 52;
  localparam int IDEA_LIST_W      = 896;
  localparam int IDEA_ROT         = 25;

  // Derived: working key width, groups per schedule, index of the short group.
  localparam int IDEA_KEY_W       = 128;
  localparam int IDEA_NUM_GROUPS  = 7;
  localparam int IDEA_LAST_GRP    = 6;
  localparam int IDEA_LAST_BITS   = (IDEA_NUM_SUBKEYS % 8) * IDEA_SUBKEY_W;  // 64
  localparam int IDEA_USED_W      = IDEA_NUM_SUBKEYS * IDEA_SUBKEY_W;        // 832
  localparam int IDEA_PAD_W       = IDEA_LIST_W - IDEA_USED_W;               // 64

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } idea_state_e;

endpackage

// File: rtl/idea_rot25.sv
// ---------------------------------------------------------------------------
// idea_rot25
//   Combinational 128-bit rotate-left by 25 for the IDEA key schedule.
//   Index 0 is the most significant bit, so rotating left moves bit i+25
//   into position i. Pure wiring, no logic.
//
//   Ports:
//     din   in  [0:127]  working key before rotation
//     dout  out [0:127]  {din[25:127], din[0:24]}
// ---------------------------------------------------------------------------
module idea_rot25
  import idea_pkg::*;
(
  input  logic [0:127] din,
  output logic [0:127] dout
);

  for (genvar gi = 0; gi < IDEA_KEY_W; gi++) begin : g_bit
    assign dout[gi] = din[(gi + IDEA_ROT) % IDEA_KEY_W];
  end

endmodule

// File: rtl/idea_key_expander.sv
// ---------------------------------------------------------------------------
// idea_key_expander
//   Sequential IDEA encryption key schedule. Expands a 128-bit user key into
//   the 52 encryption subkeys, one group of eight subkeys per clock, rotating
//   the working key left by 25 bits between groups.
//
//   Ports:
//     clk       in  1        clock, rising edge
//     rst       in  1        synchronous active-high reset
//     start     in  1        request an expansion (sampled only in IDLE)
//     key       in  [0:127]  user key, key[0:15] is subkey 1
//     keysList  out [0:895]  subkey k at [k*16 +: 16]; slots 52..55 are 0
//     busy      out 1        high from the accepting edge until done falls
//     done      out 1        one-cycle pulse, keysList complete and stable
//
//   Build option:
//     IDEA_KEYEXP_CLEAR_EN  when defined, the accepting edge also zeroes the
//                           whole subkey list so a stale schedule is never
//                           visible during RUN. Default: list is only
//                           overwritten group by group.
// ---------------------------------------------------------------------------
module idea_key_expander
  import idea_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [0:127] key,
  output logic [0:895] keysList,
  output logic         busy,
  output logic         done
);

  idea_state_e          state_q, state_d;
  logic [0:127]         kreg_q, kreg_d;
  logic [2:0]           grp_q, grp_d;
  logic [0:IDEA_LIST_W-1] list_q, list_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [0:127]         kreg_rot;

  idea_rot25 u_rot25 (
    .din  (kreg_q),
    .dout (kreg_rot)
  );

  // Next-state and datapath
  always_comb begin
    state_d = state_q;
    kreg_d  = kreg_q;
    grp_d   = grp_q;
    list_d  = list_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          kreg_d  = key;
          grp_d   = 3'd0;
          busy_d  = 1'b1;
`ifdef IDEA_KEYEXP_CLEAR_EN
          list_d  = '0;
`endif
        end
      end

      RUN: begin
        // Full groups 0..5: all eight subkeys of the working key.
        for (int g = 0; g < IDEA_LAST_GRP; g++) begin
          if (grp_q == 3'(g)) begin
            list_d[g*IDEA_KEY_W +: IDEA_KEY_W] = kreg_q;
          end
        end
        // Group 6 only contributes subkeys 49..52; the rest of the
        // working key is discarded.
        if (grp_q == 3'(IDEA_LAST_GRP)) begin
          list_d[IDEA_LAST_GRP*IDEA_KEY_W +: IDEA_LAST_BITS] = kreg_q[0:IDEA_LAST_BITS-1];
          state_d = DONE;
          done_d  = 1'b1;
        end
        kreg_d = kreg_rot;
        grp_d  = grp_q + 3'd1;
      end

      DONE: begin
        // busy falls together with done; start here is ignored.
        state_d = IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // Padding slots 52..55 are never written.
    list_d[IDEA_USED_W +: IDEA_PAD_W] = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      kreg_q  <= '0;
      grp_q   <= '0;
      list_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      kreg_q  <= kreg_d;
      grp_q   <= grp_d;
      list_q  <= list_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign keysList = list_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_idea_key_expander.sv
// ---------------------------------------------------------------------------
// tb_idea_key_expander
//   Directed self-checking bench for idea_key_expander. Expected schedules
//   come from hand-computed constants and a small rotate-based reference.
//   Honours IDEA_KEYEXP_CLEAR_EN for the back-to-back stale-data check.
// ---------------------------------------------------------------------------
module tb_idea_key_expander;

  logic         clk;
  logic         rst;
  logic         start;
  logic [127:0] key;
  logic [0:895] keys_list;
  logic         busy;
  logic         done;

  int n_checks;
  int n_errors;

  idea_key_expander dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .key      (key),
    .keysList (keys_list),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: subkey s of the schedule for key k (slots >= 52 are zero).
  function automatic logic [15:0] model_sk(input logic [127:0] k, input int s);
    logic [127:0] r;
    r = k;
    if (s >= 52) return 16'h0000;
    for (int i = 0; i < s / 8; i++) r = {r[102:0], r[127:103]};
    return r[127 - 16*(s % 8) -: 16];
  endfunction

  task automatic compare_list(input string tag, input logic [127:0] k);
    for (int s = 0; s < 56; s++) begin
      check($sformatf("%s slot%0d", tag, s), 128'(keys_list[s*16 +: 16]), 128'(model_sk(k, s)));
    end
  endtask

  task automatic check_zero_list(input string tag);
    for (int c = 0; c < 7; c++) begin
      check($sformatf("%s chunk%0d", tag, c), keys_list[c*128 +: 128], 128'h0);
    end
  endtask

  // Full run with per-edge done/busy timing checks; leaves bench after E8.
  task automatic run_key(input string tag, input logic [127:0] k);
    key   = k;
    start = 1'b1;
    tick();                                   // E0
    start = 1'b0;
    key   = ~k;                               // post-accept changes must not matter
    check({tag, " busy@E0"}, 128'(busy), 128'h1);
    check({tag, " done@E0"}, 128'(done), 128'h0);
    for (int e = 1; e <= 7; e++) begin
      tick();
      check($sformatf("%s done@E%0d", tag, e), 128'(done), (e == 7) ? 128'h1 : 128'h0);
      check($sformatf("%s busy@E%0d", tag, e), 128'(busy), 128'h1);
    end
    compare_list(tag, k);
    tick();                                   // E8
    check({tag, " done@E8"}, 128'(done), 128'h0);
    check({tag, " busy@E8"}, 128'(busy), 128'h0);
    $display("run %s key=%h finished", tag, k);
  endtask

  localparam logic [127:0] KEY_STD  = 128'h0001_0002_0003_0004_0005_0006_0007_0008;
  localparam logic [127:0] KEY_ALT  = 128'h2b7e_1516_28ae_d2a6_abf7_1588_09cf_4f3c;
  localparam logic [127:0] KEY_THR  = 128'hdead_beef_0123_4567_89ab_cdef_f00d_cafe;
  localparam logic [127:0] KEY_ONES = {128{1'b1}};

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst   = 1'b1;
    start = 1'b0;
    key   = '0;

    // Reset state
    tick();
    tick();
    check("rst busy", 128'(busy), 128'h0);
    check("rst done", 128'(done), 128'h0);
    check_zero_list("rst list");
    rst = 1'b0;
    tick();
    $display("reset sequence finished");

    // Standard vector with hand-computed subkeys
    run_key("std", KEY_STD);
    check("std sk1-8",   keys_list[0   +: 128], KEY_STD);
    check("std sk9-16",  keys_list[128 +: 128], 128'h0400_0600_0800_0a00_0c00_0e00_1000_0200);
    check("std sk49-52", 128'(keys_list[768 +: 64]), 128'h0080_00c0_0100_0140);
    check("std pad",     128'(keys_list[832 +: 64]), 128'h0);
    tick();
    check("std stable", keys_list[128 +: 128], 128'h0400_0600_0800_0a00_0c00_0e00_1000_0200);

    // Start re-pulsed at E3 with a different key is ignored
    key   = KEY_ALT;
    start = 1'b1;
    tick();                                   // E0
    start = 1'b0;
    tick();
    tick();                                   // E2
    key   = KEY_THR;
    start = 1'b1;
    tick();                                   // E3
    start = 1'b0;
    for (int e = 4; e <= 7; e++) tick();
    check("repulse done@E7", 128'(done), 128'h1);
    compare_list("repulse", KEY_ALT);
    tick();                                   // E8
    check("repulse done@E8", 128'(done), 128'h0);
    tick();
    check("repulse no requeue", 128'(busy), 128'h0);
    $display("run repulse finished");

    // Reset asserted at E4 mid-run
    key   = KEY_THR;
    start = 1'b1;
    tick();                                   // E0
    start = 1'b0;
    for (int e = 1; e <= 3; e++) tick();
    rst = 1'b1;
    tick();                                   // E4 with reset
    rst = 1'b0;
    check("midrst busy", 128'(busy), 128'h0);
    check("midrst done", 128'(done), 128'h0);
    check_zero_list("midrst list");
    tick();
    check("midrst idle busy", 128'(busy), 128'h0);
    $display("run midrst finished");
    run_key("afterrst", KEY_THR);

    // Back-to-back with start held high
    key   = KEY_STD;
    start = 1'b1;
    tick();                                   // E0
    key   = KEY_ALT;
    for (int e = 1; e <= 7; e++) tick();
    check("b2b first done@E7", 128'(done), 128'h1);
    compare_list("b2b first", KEY_STD);
    tick();                                   // E8
    check("b2b busy@E8", 128'(busy), 128'h0);
    tick();                                   // E9: second accept
    check("b2b busy@E9", 128'(busy), 128'h1);
    start = 1'b0;
    tick();
    tick();                                   // E11
    for (int s = 24; s < 52; s++) begin
`ifdef IDEA_KEYEXP_CLEAR_EN
      check($sformatf("b2b stale slot%0d", s), 128'(keys_list[s*16 +: 16]), 128'h0);
`else
      check($sformatf("b2b stale slot%0d", s), 128'(keys_list[s*16 +: 16]), 128'(model_sk(KEY_STD, s)));
`endif
    end
    check("b2b grp0@E11", keys_list[0 +: 128], KEY_ALT);
    for (int e = 12; e <= 16; e++) begin
      tick();
      check($sformatf("b2b done@E%0d", e), 128'(done), (e == 16) ? 128'h1 : 128'h0);
    end
    compare_list("b2b second", KEY_ALT);
    tick();                                   // E17
    check("b2b done@E17", 128'(done), 128'h0);
    check("b2b busy@E17", 128'(busy), 128'h0);
    $display("run b2b finished");

    // All-ones key
    run_key("ones", KEY_ONES);
    check("ones sk1-8",   keys_list[0   +: 128], {128{1'b1}});
    check("ones sk49-52", 128'(keys_list[768 +: 64]), 128'hffff_ffff_ffff_ffff);
    check("ones pad",     128'(keys_list[832 +: 64]), 128'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
